vpu_dst_port: RTL

// - Destination port for the VPU ALU datapath: takes the ALU result stream (result_o of the
//   add/sub units) and writes it to the VPU SRAM write port at consecutive addresses.
// - A small FIFO between the ALU and the SRAM arbiter absorbs grant stalls.
// - The VPU controller starts a transfer with base address and element count; the block

---
 rtl/vpu_dst_port.sv | 102 ++++++++++
 1 files changed

// File: rtl/vpu_dst_port.sv
// VPU destination port: buffers ALU results in a small FIFO and writes them to SRAM at
// consecutive addresses. Optional stall counter enabled by VPU_DST_PORT_PERF_CNT_EN.
module vpu_dst_port #(
  parameter int OPERAND_WIDTH = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH     = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_WIDTH-1:0]    dst_addr_i,
  input  logic [LEN_WIDTH-1:0]     len_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic [OPERAND_WIDTH-1:0] result_i,
  input  logic                     result_valid_i,
  output logic                     result_ready_o,
  output logic                     sram_w_en_o,
  output logic [ADDR_WIDTH-1:0]    sram_w_addr_o,
  output logic [OPERAND_WIDTH-1:0] sram_w_data_o,
  input  logic                     sram_w_gnt_i
`ifdef VPU_DST_PORT_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]               state;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [LEN_WIDTH-1:0]     len_q, acc_cnt, wr_cnt;
  logic [OPERAND_WIDTH-1:0] mem [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]              wr_ptr, rd_ptr;

  logic fifo_empty, fifo_full, start_ok, push, pop, last_wr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign start_ok   = start_i && (state == S_IDLE);
  assign push       = result_valid_i && result_ready_o;
  assign pop        = sram_w_en_o && sram_w_gnt_i;
  assign last_wr    = pop && ((wr_cnt + LEN_WIDTH'(1)) == len_q);

  assign busy_o         = (state != S_IDLE);
  assign done_o         = (state == S_DONE);
  assign result_ready_o = (state == S_RUN) && (acc_cnt < len_q) && !fifo_full;
  assign sram_w_en_o    = (state == S_RUN) && !fifo_empty;
  assign sram_w_addr_o  = base_q + ADDR_WIDTH'(wr_cnt);
  assign sram_w_data_o  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_ok) state <= (len_i == '0) ? S_DONE : S_RUN;
        S_RUN:  if (last_wr) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (start_ok) begin
        base_q  <= dst_addr_i;
        len_q   <= len_i;
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= result_i;
        wr_ptr  <= wr_ptr + 1'b1;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

`ifdef VPU_DST_PORT_PERF_CNT_EN
  // Saturating count of cycles a write request waits for grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            stall_cnt_o <= '0;
    else if (start_ok)                                  stall_cnt_o <= '0;
    else if (sram_w_en_o && !sram_w_gnt_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
  end
`endif

endmodule
